// File: rtl/miriscv_dmem_pkg.sv
// Shared data-memory definitions: FSM encodings, wait-state limit, lane geometry, LSU size codes.
package miriscv_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned WAIT_STATES_MAX = 7;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned NUM_LANES       = 4;

  localparam logic [1:0] LDST_B = 2'b00;
  localparam logic [1:0] LDST_H = 2'b01;
  localparam logic [1:0] LDST_W = 2'b10;

endpackage

// File: rtl/miriscv_dmem_if.sv
// Core-side data bus: request/grant handshake plus a one-cycle response strobe.
interface miriscv_dmem_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/miriscv_dmem_array.sv
// Word-organised RAM with per-lane byte writes and a registered read port.
// Read data only updates on a read access, so it holds across stores and idle cycles.
module miriscv_dmem_array
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 en,
  input  logic                 we,
  input  logic [NUM_LANES-1:0] be,
  input  logic [AW-1:0]        addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int n = 0; n < NUM_LANES; n++) begin
          if (be[n]) mem[addr][n*BYTE_W +: BYTE_W] <= wdata[n*BYTE_W +: BYTE_W];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/miriscv_dmem.sv
// Data memory slave: IDLE grants combinationally, optional WAIT countdown, one-cycle RESP strobe.
// The array is touched only on the edge entering RESP, so an aborted access never writes.
module miriscv_dmem
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  miriscv_dmem_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned WS = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  dmem_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      req_addr, req_wdata;
  logic             req_we;
  logic [3:0]       req_be;
  logic             rvalid_q, err_q, rdata_zero;

  logic             gnt, acc_en, acc_we, in_range;
  logic [31:0]      acc_addr, acc_wdata, acc_off, arr_rdata;
  logic [3:0]       acc_be;
  logic             unused_off_bits;

  assign gnt = arstn_i && (state == IDLE) && bus.data_req;

  // With no wait states the array sees the live bus fields on the grant edge itself.
  always_comb begin
    acc_addr  = req_addr;
    acc_wdata = req_wdata;
    acc_we    = req_we;
    acc_be    = req_be;
    acc_en    = 1'b0;
    if (state == IDLE) begin
      acc_addr  = bus.data_addr;
      acc_wdata = bus.data_wdata;
      acc_we    = bus.data_we;
      acc_be    = bus.data_be;
      acc_en    = gnt && (WS == 0);
    end else if (state == WAIT) begin
      acc_en    = (cnt == CNT_W'(1));
    end
  end

  assign acc_off         = acc_addr - BASE_ADDR;
  assign in_range        = (acc_addr >= BASE_ADDR) && ({1'b0, acc_addr} < LIMIT);
  assign unused_off_bits = ^{acc_off[31:AW+2], acc_off[1:0]};

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_we     <= 1'b0;
      req_be     <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      rvalid_q <= acc_en;
      err_q    <= acc_en && !in_range;
      // Errored responses force zero read data; only a good load exposes the array word again.
      if (acc_en) begin
        if (!in_range)    rdata_zero <= 1'b1;
        else if (!acc_we) rdata_zero <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (gnt) begin
            req_addr  <= bus.data_addr;
            req_wdata <= bus.data_wdata;
            req_we    <= bus.data_we;
            req_be    <= bus.data_be;
            if (WS == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WS);
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  miriscv_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i (clk_i),
    .en    (acc_en && in_range),
    .we    (acc_we),
    .be    (acc_be),
    .addr  (acc_off[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign bus.data_gnt    = gnt;
  assign bus.data_rvalid = rvalid_q;
  assign bus.data_err    = err_q;
  assign bus.data_rdata  = rdata_zero ? 32'h0 : arr_rdata;

endmodule

// File: tb/tb_miriscv_dmem.sv
// Bench for miriscv_dmem: three instances (0, 1 and 3 wait states) behind one shared driver.
module tb_miriscv_dmem;

  logic        clk = 1'b0;
  logic        arstn;
  logic [1:0]  sel;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt_m, rvalid_m, err_m;
  logic [31:0] rdata_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  miriscv_dmem_if if0 ();
  miriscv_dmem_if if1 ();
  miriscv_dmem_if if3 ();

  miriscv_dmem #(.WAIT_STATES(0)) dut0 (.clk_i(clk), .arstn_i(arstn), .bus(if0));
  miriscv_dmem #(.WAIT_STATES(1)) dut1 (.clk_i(clk), .arstn_i(arstn), .bus(if1));
  miriscv_dmem #(.WAIT_STATES(3)) dut3 (.clk_i(clk), .arstn_i(arstn), .bus(if3));

  assign if0.data_req = req && (sel == 2'd0);
  assign if1.data_req = req && (sel == 2'd1);
  assign if3.data_req = req && (sel == 2'd3);
  assign {if0.data_we, if0.data_be, if0.data_addr, if0.data_wdata} = {we, be, addr, wdata};
  assign {if1.data_we, if1.data_be, if1.data_addr, if1.data_wdata} = {we, be, addr, wdata};
  assign {if3.data_we, if3.data_be, if3.data_addr, if3.data_wdata} = {we, be, addr, wdata};

  assign gnt_m    = (sel == 2'd0) ? if0.data_gnt    : (sel == 2'd1) ? if1.data_gnt    : if3.data_gnt;
  assign rvalid_m = (sel == 2'd0) ? if0.data_rvalid : (sel == 2'd1) ? if1.data_rvalid : if3.data_rvalid;
  assign err_m    = (sel == 2'd0) ? if0.data_err    : (sel == 2'd1) ? if1.data_err    : if3.data_err;
  assign rdata_m  = (sel == 2'd0) ? if0.data_rdata  : (sel == 2'd1) ? if1.data_rdata  : if3.data_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction on the selected instance, starting at the next falling edge.
  task automatic txn(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                     output int wt, output int lat, output logic [31:0] rd, output logic er,
                     output logic rv2, output logic er2);
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1;
    wt = 0;
    while (!gnt_m && wt < 20) begin
      @(negedge clk); #1; wt++;
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    @(negedge clk);
    lat = 1;
    while (!rvalid_m && lat < 12) begin
      @(negedge clk); lat++;
    end
    rd = rdata_m; er = err_m;
    @(negedge clk);
    rv2 = rvalid_m; er2 = err_m;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[16];
    int          wt, lat, rv_cnt;
    logic [31:0] rd;
    logic        er, rv2, er2;

    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'hC, 32'h0000_0012, 32'h1234_1234, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_BEEF};
    vecs[4]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 4'h2, 32'h0000_0021, 32'h5555_5555, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000_0023, 32'h0,         1'b0, 1'b1, 32'h1122_5544};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h1234_BEEF};
    vecs[9]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 4'h0, 32'h0000_1000, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5};
    vecs[13] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'h0BAD_CAFE};
    vecs[15] = '{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b1, 32'h0};

    // Reset: grant suppressed even with a request present, outputs zero.
    arstn = 1'b0; sel = 2'd1;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    check("reset_gnt", {31'h0, gnt_m}, 32'h0);
    check("reset_rvalid", {31'h0, rvalid_m}, 32'h0);
    check("reset_err", {31'h0, err_m}, 32'h0);
    check("reset_rdata", rdata_m, 32'h0);
    req = 1'b0;
    arstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, wt, lat, rd, er, rv2, er2);
      check($sformatf("v%0d_gnt_wait", i), wt, 0);
      check($sformatf("v%0d_latency", i), lat, 2);
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_rvalid_drop", i), {31'h0, rv2}, 32'h0);
      check($sformatf("v%0d_err_drop", i), {31'h0, er2}, 32'h0);
    end

    // Request held while busy: refused until IDLE, then served with its own fields.
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h10;
    #1 check("busy_first_gnt", {31'h0, gnt_m}, 32'h1);
    @(posedge clk); #1 addr = 32'h20;
    @(negedge clk) check("busy_wait_gnt", {31'h0, gnt_m}, 32'h0);
    @(negedge clk) check("busy_resp_gnt", {31'h0, gnt_m}, 32'h0);
    check("busy_resp_rvalid", {31'h0, rvalid_m}, 32'h1);
    check("busy_resp_rdata", rdata_m, 32'h1234_BEEF);
    @(negedge clk) check("busy_second_gnt", {31'h0, gnt_m}, 32'h1);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk) check("busy_second_wait", {31'h0, rvalid_m}, 32'h0);
    @(negedge clk) check("busy_second_rvalid", {31'h0, rvalid_m}, 32'h1);
    check("busy_second_rdata", rdata_m, 32'h1122_5544);

    // Zero wait states: back-to-back loads with the request held.
    sel = 2'd0;
    txn(1'b1, 4'hF, 32'h40, 32'h0102_0304, wt, lat, rd, er, rv2, er2);
    check("ws0_store_latency", lat, 1);
    txn(1'b1, 4'hF, 32'h44, 32'h0506_0708, wt, lat, rd, er, rv2, er2);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h40;
    #1 check("b2b_gnt_T", {31'h0, gnt_m}, 32'h1);
    @(posedge clk); #1 addr = 32'h44;
    @(negedge clk) check("b2b_rvalid_T1", {31'h0, rvalid_m}, 32'h1);
    check("b2b_rdata_T1", rdata_m, 32'h0102_0304);
    check("b2b_gnt_T1", {31'h0, gnt_m}, 32'h0);
    @(negedge clk) check("b2b_gnt_T2", {31'h0, gnt_m}, 32'h1);
    check("b2b_rvalid_T2", {31'h0, rvalid_m}, 32'h0);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk) check("b2b_rvalid_T3", {31'h0, rvalid_m}, 32'h1);
    check("b2b_rdata_T3", rdata_m, 32'h0506_0708);
    @(negedge clk) check("b2b_rvalid_T4", {31'h0, rvalid_m}, 32'h0);
    check("b2b_gnt_T4", {31'h0, gnt_m}, 32'h0);

    // Three wait states: a store aborted by reset in WAIT leaves the word intact.
    sel = 2'd3;
    txn(1'b1, 4'hF, 32'h30, 32'h7777_8888, wt, lat, rd, er, rv2, er2);
    check("ws3_store_latency", lat, 4);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h30; wdata = 32'hFFFF_FFFF;
    #1 check("abort_gnt", {31'h0, gnt_m}, 32'h1);
    @(posedge clk); #1 req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    @(negedge clk) arstn = 1'b0;
    @(negedge clk) arstn = 1'b1;
    rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid_m) rv_cnt++;
    end
    check("abort_no_rvalid", rv_cnt, 0);
    txn(1'b0, 4'h0, 32'h30, 32'h0, wt, lat, rd, er, rv2, er2);
    check("abort_next_gnt_wait", wt, 0);
    check("abort_next_latency", lat, 4);
    check("abort_word_intact", rd, 32'h7777_8888);
    check("abort_next_err", {31'h0, er}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
